// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one combinational instruction-ROM port between the
// instruction-fetch (IF) and data-side (DM) requesters. At most one ROM
// access is granted per cycle, and the response comes back one cycle later.
// The arbiter also latches the first access the ROM reports as inaccessible.
// Optional feature: define ROM_ARB_PREFETCH_EN to add a one-entry sequential
// IF prefetch buffer that is filled during idle cycles.
module rom_arbiter #(
  parameter int MAX_WAIT = 3,
  parameter int WAIT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        dm_req,
  input  logic [31:0] dm_addr,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        dm_err,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        rom_accessable,
  output logic        err_valid,
  output logic [31:0] err_addr,
  input  logic        err_clr
);

  logic [WAIT_W-1:0] r_if_wait;
  logic              r_if_rvalid, r_if_err, r_dm_rvalid, r_dm_err;
  logic [31:0]       r_if_rdata, r_dm_rdata;
  logic              r_err_valid;
  logic [31:0]       r_err_addr;

  logic        w_if_pri, w_if_hit, w_if_rom_gnt, w_dm_gnt, w_if_gnt;
  logic        w_acc_err;
  logic [31:0] w_idle_addr, w_pf_data, w_rom_word;

`ifdef ROM_ARB_PREFETCH_EN
  logic        r_pf_valid, r_if_seen;
  logic [31:0] r_pf_addr, r_pf_data, r_last_if_addr;
  logic        w_pf_fetch;

  // A ROM cycle with no requests fetches the next sequential IF word, but
  // only after an IF grant has established where the stream is.
  assign w_pf_fetch  = ~if_req & ~dm_req & r_if_seen;
  assign w_idle_addr = w_pf_fetch ? (r_last_if_addr + 32'd4) : 32'h0;
  assign w_if_hit    = if_req & r_pf_valid & (if_addr == r_pf_addr);
  assign w_pf_data   = r_pf_data;

  // Fill the prefetch buffer on idle cycles and track the IF stream.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pf_valid     <= 1'b0;
      r_pf_addr      <= 32'h0;
      r_pf_data      <= 32'h0;
      r_last_if_addr <= 32'h0;
      r_if_seen      <= 1'b0;
    end else begin
      if (w_pf_fetch && rom_accessable) begin
        r_pf_valid <= 1'b1;
        r_pf_addr  <= w_idle_addr;
        r_pf_data  <= rom_data;
      end
      if (w_if_gnt) begin
        r_last_if_addr <= if_addr;
        r_if_seen      <= 1'b1;
      end
    end
  end
`else
  assign w_idle_addr = 32'h0;
  assign w_if_hit    = 1'b0;
  assign w_pf_data   = 32'h0;
`endif

  // IF takes priority over DM once it has been denied MAX_WAIT cycles in a row.
  // A prefetch hit does not use the ROM, so DM can still be granted that cycle.
  assign w_if_pri     = if_req & (r_if_wait == WAIT_W'(MAX_WAIT));
  assign w_dm_gnt     = dm_req & ~(w_if_pri & ~w_if_hit);
  assign w_if_rom_gnt = if_req & ~w_if_hit & ~w_dm_gnt;
  assign w_if_gnt     = w_if_rom_gnt | w_if_hit;
  assign w_acc_err    = (w_dm_gnt | w_if_rom_gnt) & ~rom_accessable;
  assign w_rom_word   = rom_accessable ? rom_data : 32'h0;

  // Drive the ROM with the winning address; idle cycles use the prefetch address.
  always_comb begin
    // NOTE: rom_addr is given a default before any branch, so no path can infer a latch.
    rom_addr = w_idle_addr;
    if (w_dm_gnt)          rom_addr = dm_addr;
    else if (w_if_rom_gnt) rom_addr = if_addr;
  end

  // Register the response for each port. The wait counter and error capture
  // are updated on the same edge.
  always_ff @(posedge clk) begin
    // NOTE: synchronous active-low reset. Every state bit is cleared here,
    // because this block has no memory arrays.
    if (!reset) begin
      r_if_wait   <= '0;
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= 32'h0;
      r_if_err    <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_dm_rdata  <= 32'h0;
      r_dm_err    <= 1'b0;
      r_err_valid <= 1'b0;
      r_err_addr  <= 32'h0;
    end else begin
      // NOTE: use non-blocking assignments so that every register samples pre-edge values.
      r_if_rvalid <= w_if_gnt;
      r_dm_rvalid <= w_dm_gnt;
      r_if_err    <= w_if_rom_gnt & ~rom_accessable;
      r_dm_err    <= w_dm_gnt & ~rom_accessable;
      if (w_if_hit)          r_if_rdata <= w_pf_data;
      else if (w_if_rom_gnt) r_if_rdata <= w_rom_word;
      if (w_dm_gnt)          r_dm_rdata <= w_rom_word;

      if (if_req && !w_if_gnt) begin
        if (r_if_wait != WAIT_W'(MAX_WAIT)) r_if_wait <= r_if_wait + 1'b1;
      end else begin
        r_if_wait <= '0;
      end

      // When a clear and a new error arrive in the same cycle, the new error is captured.
      if (w_acc_err && (!r_err_valid || err_clr)) begin
        r_err_valid <= 1'b1;
        r_err_addr  <= rom_addr;
      end else if (err_clr) begin
        r_err_valid <= 1'b0;
      end
    end
  end

  assign if_gnt    = w_if_gnt;
  assign dm_gnt    = w_dm_gnt;
  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign if_err    = r_if_err;
  assign dm_rvalid = r_dm_rvalid;
  assign dm_rdata  = r_dm_rdata;
  assign dm_err    = r_dm_err;
  assign err_valid = r_err_valid;
  assign err_addr  = r_err_addr;

endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Shares the single combinational instruction ROM port between two requesters: instruction fetch (IF) and a data-side read port (DM), used for loads from ROM space.
- Grants at most one ROM access per cycle and registers the response, so each port sees a fixed one-cycle read latency.
- Captures the first access the ROM reports as not accessible, for the exception logic.
- Sits between the CPU pipeline and the ROM peripheral; the ROM itself is unchanged.

Parameters:
- MAX_WAIT, 3: consecutive cycles IF may be denied before it takes priority over DM (legal 1..15).
- WAIT_W, 4: width of the IF wait counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset; sampled on clk rising edge.
- if_req  in  1  IF read request; if_addr must stay stable while if_req=1 and if_gnt=0.
- if_addr  in  32  IF byte address.
- if_gnt  out  1  combinational; IF request accepted this cycle.
- if_rvalid  out  1  registered; one-cycle pulse, response for the previous IF grant.
- if_rdata  out  32  registered IF read data.
- if_err  out  1  registered; qualifies if_rvalid, address not accessible.
- dm_req, dm_addr, dm_gnt, dm_rvalid, dm_rdata, dm_err: same as the IF port, for the data requester.
- rom_addr  out  32  combinational address to the ROM.
- rom_data  in  32  ROM read data.
- rom_accessable  in  1  ROM reports the current address as valid.
- err_valid  out  1  sticky; an inaccessible access has been captured.
- err_addr  out  32  address of the first captured inaccessible access.
- err_clr  in  1  clears err_valid on the next edge.

Behaviour:
- Reset (reset=0 at an edge): all registered outputs go to 0 (rvalid, rdata, err, err_valid, err_addr), wait counter goes to 0, prefetch state is invalidated. Combinational outputs follow the reset state the same cycle.
- Arbitration (combinational, evaluated each cycle):
  - DM wins by default.
  - IF wins if if_wait==MAX_WAIT.
  - A lone requester always wins; the loser's gnt is 0.
- rom_addr = winner's address; 32'h0 when there are no requests.
- Latency: the edge ending a grant cycle registers the response.
  - Winner's rvalid goes to 1 for exactly one cycle.
  - rdata = rom_accessable ? rom_data : 32'h0.
  - err = ~rom_accessable.
- rdata holds its last value when rvalid=0. The loser's rvalid is 0.
- if_wait:
  - Increments (saturating at MAX_WAIT) when if_req=1 and if_gnt=0.
  - Clears to 0 when if_gnt=1 or if_req=0.
  - Guarantees IF a grant within MAX_WAIT+1 cycles under continuous DM traffic.
- Error capture:
  - On any granted access with rom_accessable=0 while err_valid=0: err_addr ← address, err_valid ← 1.
  - Later errors do not overwrite err_addr.
  - err_clr=1 clears err_valid. If err_clr and a new error coincide, the new error is captured (set wins).
- Misaligned addresses (addr[1:0]≠0) are forwarded unchanged; the ROM's accessable=0 yields err.
- The requester drives if_req/dm_req low in the cycle after gnt unless it issues a new access. Back-to-back grants to the same port are allowed every cycle.
- reset=0 mid-access drops any pending response: no rvalid the following cycle.

Optional Feature:
- Macro ROM_ARB_PREFETCH_EN.
- Defined: one-entry sequential IF prefetch buffer (pf_valid, pf_addr, pf_data) plus a last-IF-address register.
  - In a cycle with no requests, once an IF grant has occurred since reset, rom_addr = last_if_addr+4.
  - At the edge, if rom_accessable=1: pf_valid←1, pf_addr←that address, pf_data←rom_data. If not accessible, the buffer is unchanged.
  - Hit (if_req=1, pf_valid=1, if_addr==pf_addr): if_gnt=1 regardless of DM; the ROM is left to DM, so DM can be granted the same cycle. Next cycle if_rvalid=1, if_rdata=pf_data, if_err=0.
  - A hit counts as an IF grant (clears if_wait, updates last_if_addr). The buffer stays valid until overwritten or reset.
- Undefined: no prefetch registers; idle cycles drive rom_addr=0; behaviour is the plain arbitration above.

Test Plan:
- Boot ROM model (word0=32'h3c114000, word1=32'h26310000, word2=32'h02200008, addr 0x0C not accessible). IF only, addr 0x0 → if_gnt same cycle; next cycle if_rvalid=1, if_rdata=32'h3c114000, if_err=0.
- IF 0x4 and DM 0x8 together → dm_gnt=1, if_gnt=0; next cycle dm_rdata=32'h02200008. IF granted the following cycle with 32'h26310000.
- DM requests every cycle, IF held at 0x0, MAX_WAIT=3 → if_gnt=1 exactly on the 4th cycle of IF's request.
- DM read of 0x0000000C → dm_err=1, dm_rdata=0, err_valid=1, err_addr=32'h0000000C. A second error at 0x00000010 leaves err_addr unchanged. err_clr with a new error at 0x10 the same cycle → err_addr=32'h10.
- reset=0 asserted in a grant cycle → next cycle all rvalid=0, err_valid=0, if_rdata=0.
- With ROM_ARB_PREFETCH_EN: IF 0x0, one idle cycle, then IF 0x4 with DM 0x8 in the same cycle → both gnt=1; next cycle if_rdata=32'h26310000 and dm_rdata=32'h02200008.
